// File: rtl/reg_file_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Consumed by reg_file_mp and reg_file_sweep.
package reg_file_mp_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;
   localparam int NR_DEF = 2;

endpackage

// File: rtl/reg_file_sweep.sv
// Clear-sweep sequencer: walks registers 1 .. 2**AW-1, clearing one per cycle.
//  state | meaning
//  IDLE  | no sweep; INIT starts one with the pointer at 1
//  SWEEP | clear register at ptr, advance; leave after the last register
module reg_file_sweep
   import reg_file_mp_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          init,
   output logic          busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST = '1;

   sweep_state_t  state, state_nxt;
   logic [AW-1:0] ptr, ptr_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         busy  <= (state_nxt == SWEEP);
      end
   end

   // Pointer wraps to 0 when the last register is cleared.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (init) begin
               state_nxt = SWEEP;
               ptr_nxt   = AW'(1);
            end
         end
         SWEEP: begin
            ptr_nxt = ptr + AW'(1);
            if (ptr == LAST) state_nxt = IDLE;
         end
      endcase
   end

   assign clr_en   = (state == SWEEP);
   assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Two-write / NR-read register file with register 0 tied to zero and a clear sweep.
// Define REG_FILE_MP_BYPASS_EN for write-first reads; default build is read-first.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int NR = NR_DEF
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             WR0,
   input  logic [AW-1:0]    AD0,
   input  logic [DW-1:0]    D0,
   input  logic             WR1,
   input  logic [AW-1:0]    AD1,
   input  logic [DW-1:0]    D1,
   input  logic [NR*AW-1:0] RA,
   output logic [NR*DW-1:0] RD,
   input  logic             INIT,
   output logic             BUSY,
   output logic             DROP
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0] mem [DEPTH];
   logic          clr_en;
   logic [AW-1:0] clr_addr;
   logic          v0, v1, blocked, we0, we1, drop_nxt;

   reg_file_sweep #(.AW(AW)) u_sweep (
      .clk      (CLK),
      .rst_n    (CLR),
      .init     (INIT),
      .busy     (BUSY),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   // Address-0 writes are no-ops everywhere, including the DROP logic.
   assign v0       = WR0 && (AD0 != '0);
   assign v1       = WR1 && (AD1 != '0);
   assign blocked  = BUSY || INIT;
   assign we0      = v0 && !blocked;
   assign we1      = v1 && !blocked;
   assign drop_nxt = blocked ? (v0 || v1) : (v0 && v1 && (AD0 == AD1));

   // Port 0 is assigned last so it wins an address collision.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (clr_en) mem[clr_addr] <= '0;
         if (we1)    mem[AD1]      <= D1;
         if (we0)    mem[AD0]      <= D0;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) DROP <= 1'b0;
      else      DROP <= drop_nxt;
   end

   for (genvar g = 0; g < NR; g++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] val;
      assign ra = RA[g*AW +: AW];
`ifdef REG_FILE_MP_BYPASS_EN
      assign val = (we0 && (AD0 == ra)) ? D0 :
                   (we1 && (AD1 == ra)) ? D1 : mem[ra];
`else
      assign val = mem[ra];
`endif
      assign RD[g*DW +: DW] = CLR ? val : '0;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a default 32x32/2R instance plus a 16-bit/4R instance.
// Honors REG_FILE_MP_BYPASS_EN to pick write-first or read-first expectations.
module tb_reg_file_mp;

   typedef struct {
      string       tag;
      logic [63:0] rd;
      logic        busy;
      logic        drop;
      bit          b;
   } exp_t;

   logic        clk;
   logic        clr, wr0, wr1, init, busy, drop;
   logic [4:0]  ad0, ad1;
   logic [31:0] d0, d1;
   logic [9:0]  ra;
   logic [63:0] rd;

   logic        clrb, wr0b, wr1b, initb, busyb, dropb;
   logic [4:0]  ad0b, ad1b;
   logic [15:0] d0b, d1b;
   logic [19:0] rab;
   logic [63:0] rdb;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] ma [32];
   int          busy_left;
   bit          drop_a;
   logic [15:0] mb [32];
   bit          drop_b;

   reg_file_mp u_dut (
      .CLK(clk), .CLR(clr), .WR0(wr0), .AD0(ad0), .D0(d0), .WR1(wr1), .AD1(ad1), .D1(d1),
      .RA(ra), .RD(rd), .INIT(init), .BUSY(busy), .DROP(drop)
   );

   reg_file_mp #(.DW(16), .AW(5), .NR(4)) u_dut4 (
      .CLK(clk), .CLR(clrb), .WR0(wr0b), .AD0(ad0b), .D0(d0b), .WR1(wr1b), .AD1(ad1b), .D1(d1b),
      .RA(rab), .RD(rdb), .INIT(initb), .BUSY(busyb), .DROP(dropb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s actual=%h expected=%h", tag, what, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (!e.b) begin
            chk(e.tag, "rd", rd, e.rd);
            chk(e.tag, "busy", 64'(busy), 64'(e.busy));
            chk(e.tag, "drop", 64'(drop), 64'(e.drop));
         end else begin
            chk(e.tag, "rd4", rdb, e.rd);
            chk(e.tag, "busy4", 64'(busyb), 64'(e.busy));
            chk(e.tag, "drop4", 64'(dropb), 64'(e.drop));
         end
      end
   end

   // One clock of stimulus on the default instance; model advances to the next edge.
   task automatic step(input string tag, input bit c,
                       input bit w0, input logic [4:0] a0, input logic [31:0] x0,
                       input bit w1, input logic [4:0] a1, input logic [31:0] x1,
                       input bit in, input logic [4:0] r0, input logic [4:0] r1);
      exp_t        e;
      bit          blk, v0, v1;
      logic [4:0]  rs [2];
      logic [31:0] rv;
      clr = c; wr0 = w0; ad0 = a0; d0 = x0; wr1 = w1; ad1 = a1; d1 = x1;
      init = in; ra = {r1, r0};
      rs[0] = r0; rs[1] = r1;
      e.rd = '0; e.busy = 1'b0; e.drop = 1'b0; e.tag = tag; e.b = 1'b0;
      if (!c) begin
         foreach (ma[k]) ma[k] = '0;
         busy_left = 0;
         drop_a    = 1'b0;
      end else begin
         v0  = w0 && (a0 != 0);
         v1  = w1 && (a1 != 0);
         blk = (busy_left > 0) || in;
         for (int i = 0; i < 2; i++) begin
            rv = ma[rs[i]];
`ifdef REG_FILE_MP_BYPASS_EN
            if (!blk && v0 && a0 == rs[i])      rv = x0;
            else if (!blk && v1 && a1 == rs[i]) rv = x1;
`endif
            e.rd[i*32 +: 32] = rv;
         end
         e.busy = (busy_left > 0);
         e.drop = drop_a;
         drop_a = blk ? (v0 || v1) : (v0 && v1 && a0 == a1);
         if (!blk) begin
            if (v1) ma[a1] = x1;
            if (v0) ma[a0] = x0;
         end
         if (busy_left > 0) begin
            ma[32 - busy_left] = '0;
            busy_left--;
         end else if (in) begin
            busy_left = 31;
         end
      end
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input string tag, input logic [4:0] r0, input logic [4:0] r1);
      step(tag, 1, 0, 0, 0, 0, 0, 0, 0, r0, r1);
   endtask

   task automatic step4(input bit w0, input logic [4:0] a0, input logic [15:0] x0,
                        input bit w1, input logic [4:0] a1, input logic [15:0] x1,
                        input logic [4:0] base);
      exp_t        e;
      bit          v0, v1;
      logic [4:0]  r;
      logic [15:0] rv;
      wr0b = w0; ad0b = a0; d0b = x0; wr1b = w1; ad1b = a1; d1b = x1; initb = 1'b0;
      e.rd = '0; e.busy = 1'b0; e.tag = "nr4"; e.b = 1'b1;
      v0 = w0 && (a0 != 0);
      v1 = w1 && (a1 != 0);
      for (int i = 0; i < 4; i++) begin
         r = 5'(base + 5'(7 * i));
         rab[i*5 +: 5] = r;
         rv = mb[r];
`ifdef REG_FILE_MP_BYPASS_EN
         if (v0 && a0 == r)      rv = x0;
         else if (v1 && a1 == r) rv = x1;
`endif
         e.rd[i*16 +: 16] = rv;
      end
      e.drop = drop_b;
      drop_b = v0 && v1 && a0 == a1;
      if (v1) mb[a1] = x1;
      if (v0) mb[a0] = x0;
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   function automatic logic [4:0] rnd_addr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
   endfunction

   initial begin
      clr = 0; wr0 = 0; wr1 = 0; ad0 = 0; ad1 = 0; d0 = 0; d1 = 0; init = 0; ra = 0;
      clrb = 0; wr0b = 0; wr1b = 0; ad0b = 0; ad1b = 0; d0b = 0; d1b = 0; initb = 0; rab = 0;
      foreach (mb[k]) mb[k] = '0;
      drop_b = 1'b0;
      @(posedge clk); #1;

      step("rst", 0, 1, 3, 32'hFFFF_FFFF, 1, 4, 32'h1, 0, 3, 4);
      step("rst2", 0, 1, 5, 32'h5, 0, 0, 0, 1, 5, 0);
      step("wr3", 1, 1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      idle("rd3", 3, 0);
      step("wr_a0", 1, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 3);
      idle("rd_a0", 0, 3);
      step("coll", 1, 1, 7, 32'h11, 1, 7, 32'h22, 0, 7, 3);
      idle("coll_rd", 7, 0);
      idle("coll_after", 7, 7);
      step("pre9", 1, 0, 0, 0, 1, 9, 32'h5555, 0, 9, 0);
      step("byp", 1, 1, 9, 32'h1234, 0, 0, 0, 0, 0, 9);
      idle("byp_after", 9, 9);

      step("w5", 1, 1, 5, 32'hA5, 1, 12, 32'hC0FFEE, 0, 5, 12);
      step("init", 1, 1, 6, 32'h66, 0, 0, 0, 1, 5, 12);
      for (int k = 0; k < 33; k++)
         step("sweep", 1, 0, 0, 0, (k == 4), 5, 32'hBAD, (k == 8), 5, 5'(k));
      for (int k = 0; k < 16; k++) idle("post", 5'(2 * k), 5'(2 * k + 1));

      for (int k = 1; k < 32; k++) step("fill", 1, 1, 5'(k), $urandom, 0, 0, 0, 0, 5'(k), 0);
      step("init2", 1, 0, 0, 0, 0, 0, 0, 1, 1, 31);
      for (int k = 1; k < 10; k++) idle("sweep2", 5'(k), 31);
      step("abort", 0, 0, 0, 0, 0, 0, 0, 0, 20, 31);
      step("abort2", 0, 1, 20, 32'h77, 0, 0, 0, 0, 20, 31);
      idle("resume", 20, 31);
      step("w_resume", 1, 1, 20, 32'hABCD, 1, 30, 32'h3030, 0, 20, 30);
      step("init3", 1, 0, 0, 0, 0, 0, 0, 1, 20, 30);
      for (int k = 0; k < 33; k++) idle("sweep3", 20, 5'(k));

      for (int n = 0; n < 400; n++)
         step("rand", 1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
              1'($urandom_range(0, 1)), rnd_addr(), $urandom,
              ($urandom_range(0, 59) == 0), rnd_addr(), rnd_addr());

      clrb = 1;
      for (int n = 0; n < 150; n++)
         step4(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom),
               1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom),
               5'($urandom_range(0, 31)));

      @(posedge clk); #1;
      chk("drain", "queue", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
